// File: rtl/binarize_pkg.sv
// rtl/binarize_pkg.sv - shared defaults, output count width and FSM encoding for popcount_binarize
package binarize_pkg;
  localparam int WL_DEF = 112;
  localparam int CW_DEF = 7;
  localparam int AW_DEF = 11;
  localparam int OCW    = 7;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;
endpackage

// File: rtl/popcount_binarize_if.sv
// rtl/popcount_binarize_if.sv - popcount input / packed word output bundle; iINV exists only with BINARIZE_INVERT_EN
interface popcount_binarize_if
  import binarize_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF
);
  logic            iEN;
  logic [CW-1:0]   idata;
  logic [3:0]      iNACC;
  logic [AW-1:0]   iTHRESH;
  logic            iFLUSH;
  logic            iREADY;
`ifdef BINARIZE_INVERT_EN
  logic            iINV;
`endif
  logic            oREADY;
  logic            oEN;
  logic [WL-1:0]   odata;
  logic [OCW-1:0]  ocount;
  logic            oOVF;

  modport master (
`ifdef BINARIZE_INVERT_EN
    output iINV,
`endif
    output iEN, idata, iNACC, iTHRESH, iFLUSH, iREADY,
    input  oREADY, oEN, odata, ocount, oOVF
  );

  modport slave (
`ifdef BINARIZE_INVERT_EN
    input  iINV,
`endif
    input  iEN, idata, iNACC, iTHRESH, iFLUSH, iREADY,
    output oREADY, oEN, odata, ocount, oOVF
  );
endinterface

// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - packs binarized neuron bits into a word, flags the last slot, clears on transfer
module bit_packer
  import binarize_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int BW = $clog2(WL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_we,
  input  logic          bit_val,
  input  logic          xfer,
  output logic [WL-1:0] pack,
  output logic [BW-1:0] bidx,
  output logic          full
);
  assign full = bit_we && (bidx == BW'(WL - 1));

  // bidx runs up to WL so it doubles as the valid-bit count while the word is held
  always_ff @(posedge clk) begin
    if (rst || xfer) begin
      pack <= '0;
      bidx <= '0;
    end else if (bit_we) begin
      pack[bidx] <= bit_val;
      bidx       <= bidx + BW'(1);
    end
  end
endmodule

// File: rtl/popcount_binarize.sv
// rtl/popcount_binarize.sv - accumulates partial popcounts per neuron, thresholds and packs bits; BINARIZE_INVERT_EN adds iINV
module popcount_binarize
  import binarize_pkg::*;
#(
  parameter int WL = WL_DEF,
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic               iCLK,
  input  logic               iRST,
  popcount_binarize_if.slave bus
);
  localparam int BW = $clog2(WL + 1);

  state_t          state, state_nxt;
  logic [AW-1:0]   acc, sum;
  logic [3:0]      pcnt, nacc_m1;
  logic            take, last, bit_we, bit_val, full, xfer, flush_go, ovf;
  logic [WL-1:0]   pack;
  logic [BW-1:0]   bidx;

  assign nacc_m1  = (bus.iNACC == 4'd0) ? 4'd0 : bus.iNACC - 4'd1;
  assign take     = bus.iEN && (state == ACC);
  assign last     = (pcnt == nacc_m1);
  assign bit_we   = take && last;
  assign sum      = acc + AW'(bus.idata);

`ifdef BINARIZE_INVERT_EN
  assign bit_val  = (sum >= bus.iTHRESH) ^ bus.iINV;
`else
  assign bit_val  = (sum >= bus.iTHRESH);
`endif

  // A bit completing in the flush cycle counts, so flush of an empty word still emits it
  assign flush_go = (state == ACC) && bus.iFLUSH && ((bidx != '0) || bit_we);
  assign xfer     = (state == OUT) && bus.iREADY;

  bit_packer #(.WL(WL), .BW(BW)) u_packer (
    .clk     (iCLK),
    .rst     (iRST),
    .bit_we  (bit_we),
    .bit_val (bit_val),
    .xfer    (xfer),
    .pack    (pack),
    .bidx    (bidx),
    .full    (full)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ACC;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (full || flush_go) state_nxt = OUT;
      OUT:     if (bus.iREADY)       state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acc  <= '0;
      pcnt <= '0;
    end else if (take) begin
      acc  <= last ? '0 : sum;
      pcnt <= last ? 4'd0 : pcnt + 4'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST)                            ovf <= 1'b0;
    else if (bus.iEN && (state != ACC))  ovf <= 1'b1;
  end

  assign bus.oREADY = (state == ACC);
  assign bus.oEN    = (state == OUT);
  assign bus.odata  = (state == OUT) ? pack : '0;
  assign bus.ocount = (state == OUT) ? OCW'(bidx) : '0;
  assign bus.oOVF   = ovf;
endmodule

// File: tb/tb_popcount_binarize.sv
// tb/tb_popcount_binarize.sv - directed bench with a per-neuron reference model; BINARIZE_INVERT_EN adds an iINV case
module tb_popcount_binarize;
  localparam int WL = 112;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  popcount_binarize_if #(.WL(WL), .CW(7), .AW(11)) bus ();

  popcount_binarize #(.WL(WL), .CW(7), .AW(11)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: list of finished neuron bits plus the running neuron sum
  bit            model_on = 1'b0;
  bit            m_hold, m_ovf, m_b;
  int            m_sum, m_cnt, m_n, m_count;
  bit            m_bits[$];
  logic [WL-1:0] m_word;

  always @(posedge clk) begin
    if (rst) begin
      m_hold = 0; m_ovf = 0; m_sum = 0; m_cnt = 0;
      m_bits.delete(); m_word = '0; m_count = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (m_hold) begin
        if (bus.iEN) m_ovf = 1;
        if (bus.iREADY) begin
          m_hold = 0; m_bits.delete(); m_word = '0; m_count = 0;
        end
      end else begin
        if (bus.iEN) begin
          m_n = (bus.iNACC == 0) ? 1 : int'(bus.iNACC);
          m_sum += int'(bus.idata);
          m_cnt++;
          if (m_cnt == m_n) begin
            m_b = (m_sum >= int'(bus.iTHRESH));
`ifdef BINARIZE_INVERT_EN
            m_b = m_b ^ bus.iINV;
`endif
            m_bits.push_back(m_b);
            m_sum = 0;
            m_cnt = 0;
          end
        end
        if (m_bits.size() == WL || (bus.iFLUSH && m_bits.size() > 0)) begin
          m_hold = 1;
          m_word = '0;
          foreach (m_bits[i]) m_word[i] = m_bits[i];
          m_count = m_bits.size();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("cyc oREADY", bus.oREADY, !m_hold);
      check("cyc oEN",    bus.oEN,    m_hold);
      check("cyc odata",  bus.odata,  m_hold ? m_word : '0);
      check("cyc ocount", bus.ocount, m_hold ? m_count : 0);
      check("cyc oOVF",   bus.oOVF,   m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_word();
    bus.iREADY = 1'b1;
    tick();
    bus.iREADY = 1'b0;
  endtask

  logic [WL-1:0] exp_word;
  logic [WL-1:0] alt_word;
  logic [WL-1:0] ones_word;
  int            d23 [6] = '{50, 50, 10, 50, 50, 9};
  int            d26 [4] = '{10, 0, 10, 10};

  initial begin
    alt_word  = 112'h5555_5555_5555_5555_5555_5555_5555;
    ones_word = '1;
    bus.iEN = 0; bus.idata = '0; bus.iNACC = 4'd1; bus.iTHRESH = '0;
    bus.iFLUSH = 0; bus.iREADY = 0;
`ifdef BINARIZE_INVERT_EN
    bus.iINV = 0;
`endif
    tick(); tick();
    check("rst oREADY", bus.oREADY, 1);
    check("rst oEN",    bus.oEN,    0);
    check("rst odata",  bus.odata,  0);
    check("rst ocount", bus.ocount, 0);
    check("rst oOVF",   bus.oOVF,   0);
    rst = 1'b0;

    // Full word of alternating partials, one partial per neuron
    bus.iNACC = 4'd1; bus.iTHRESH = 11'd56;
    for (int i = 0; i < WL; i++) begin
      bus.iEN = 1; bus.idata = (i % 2 == 0) ? 7'd60 : 7'd40;
      if (i == WL - 1) check("alt oEN before last", bus.oEN, 0);
      tick();
    end
    bus.iEN = 0;
    check("alt oEN",    bus.oEN,    1);
    check("alt odata",  bus.odata,  alt_word);
    check("alt ocount", bus.ocount, 112);
    check("alt model",  m_word,     alt_word);
    release_word();
    check("alt back to ACC", bus.oREADY, 1);

    // Three partials per neuron, exact-threshold boundary, then flush
    bus.iNACC = 4'd3; bus.iTHRESH = 11'd110;
    for (int i = 0; i < 6; i++) begin
      bus.iEN = 1; bus.idata = 7'(d23[i]);
      tick();
    end
    bus.iEN = 0; bus.iFLUSH = 1;
    tick();
    bus.iFLUSH = 0;
    check("nacc3 ocount", bus.ocount, 2);
    check("nacc3 odata",  bus.odata,  1);
    check("nacc3 model",  m_count,    2);
    release_word();

    // Flush with an empty word keeps the in-flight neuron
    bus.iNACC = 4'd2; bus.iTHRESH = 11'd50;
    bus.iEN = 1; bus.idata = 7'd30; tick();
    bus.iEN = 0; bus.iFLUSH = 1; tick();
    bus.iFLUSH = 0;
    check("empty flush oEN", bus.oEN, 0);
    bus.iEN = 1; bus.idata = 7'd30; tick();
    bus.iEN = 0; bus.iFLUSH = 1; tick();
    bus.iFLUSH = 0;
    check("carry ocount", bus.ocount, 1);
    check("carry odata",  bus.odata,  1);
    release_word();

    // iNACC=0 acts as 1; hold the word with iREADY low and poke iEN/iFLUSH
    bus.iNACC = 4'd0; bus.iTHRESH = 11'd0;
    for (int i = 0; i < WL; i++) begin
      bus.iEN = 1; bus.idata = 7'd0;
      tick();
    end
    bus.iEN = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin bus.iEN = 1; bus.iFLUSH = 1; end
      tick();
      bus.iEN = 0; bus.iFLUSH = 0;
      check("hold odata",  bus.odata,  ones_word);
      check("hold oREADY", bus.oREADY, 0);
    end
    check("hold oOVF", bus.oOVF, 1);
    release_word();
    check("hold back oREADY", bus.oREADY, 1);
    check("hold back oEN",    bus.oEN,    0);

    // Reset mid-word and mid-neuron
    bus.iNACC = 4'd2; bus.iTHRESH = 11'd20;
    for (int i = 0; i < 81; i++) begin
      bus.iEN = 1; bus.idata = 7'd15;
      tick();
    end
    bus.iEN = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst oREADY", bus.oREADY, 1);
    check("mid rst oEN",    bus.oEN,    0);
    check("mid rst odata",  bus.odata,  0);
    check("mid rst ocount", bus.ocount, 0);
    check("mid rst oOVF",   bus.oOVF,   0);
    bus.iNACC = 4'd1; bus.iTHRESH = 11'd20;
    exp_word = '0;
    for (int i = 0; i < WL; i++) begin
      bus.iEN = 1; bus.idata = 7'((i % 3) * 20);
      exp_word[i] = (i % 3) != 0;
      tick();
    end
    bus.iEN = 0;
    check("post rst ocount", bus.ocount, 112);
    check("post rst odata",  bus.odata,  exp_word);
    release_word();

    // Flush coinciding with a completed bit at bidx=4, then flush at bidx=0
    bus.iNACC = 4'd1; bus.iTHRESH = 11'd5;
    for (int i = 0; i < 4; i++) begin
      bus.iEN = 1; bus.idata = 7'(d26[i]);
      tick();
    end
    bus.iEN = 1; bus.idata = 7'd10; bus.iFLUSH = 1;
    tick();
    bus.iEN = 0; bus.iFLUSH = 0;
    check("co flush ocount", bus.ocount, 5);
    check("co flush odata",  bus.odata,  5'h1D);
    release_word();
    bus.iFLUSH = 1; tick();
    bus.iFLUSH = 0;
    check("bidx0 flush oEN", bus.oEN, 0);
    tick();
    check("bidx0 flush oEN later", bus.oEN, 0);

`ifdef BINARIZE_INVERT_EN
    bus.iNACC = 4'd1; bus.iTHRESH = 11'd56;
    bus.iEN = 1; bus.idata = 7'd70; bus.iINV = 1; tick();
    bus.iINV = 0; tick();
    bus.iEN = 0; bus.iFLUSH = 1; tick();
    bus.iFLUSH = 0;
    check("inv odata",  bus.odata,  2'b10);
    check("inv ocount", bus.ocount, 2);
    release_word();
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
